uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver, the next generation of the serial receive path. It adds configurable data width, optional parity, one or two stop bits, and line polarity. A held valid/ack output handshake with overrun detection replaces the single-cycle ready pulse. It sits between the pad synchroniser and the byte consumer, and is clocked by `ref_clk` with oversampling ticks supplied by `samp_clk`.

## Interface
- `Oversample`, 3: log2 of samples per bit; N = 2**Oversample; legal 2..6
- `DataBits`, 8: data bits per frame; legal 5..9
- `Parity`, 0: 0 = none, 1 = odd, 2 = even
- `StopBits`, 1: 1 or 2
- `IdleLevel`, 0: line level when idle and during stop bits; start bit is the inverse

- `ref_clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `samp_clk`  in  1  oversample tick enable, one `ref_clk` cycle wide, N per bit period
- `in`  in  1  serial line, already synchronised to `ref_clk`
- `ack`  in  1  consumer accepts `out`; sampled every `ref_clk` cycle
- `out`  out  DataBits  received word, LSB received first into bit 0
- `valid`  out  1  `out` holds unread data
- `parity_err`  out  1  parity of the word in `out` was wrong; qualified by `valid`
- `frame_err`  out  1  one-cycle pulse: bad stop bit, frame discarded
- `overrun`  out  1  sticky: a word was overwritten while unread
- `busy`  out  1  state != IDLE

## Operation
- Reset: state IDLE, phase 0. Outputs: `out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
- The FSM and the phase counter advance only on `ref_clk` edges with `samp_clk`=1. The `ack` clear logic runs on every `ref_clk` edge.
- Phase counter: Oversample bits. It is cleared while in IDLE and increments mod N on each tick otherwise. A sample instant is a tick where phase == N/2-1.
- IDLE: on a tick with `in` != IdleLevel, go to START.
- START: at the sample instant, if `in` == IdleLevel, return to IDLE (noise; no error). Otherwise go to DATA with bit counter 0.
- DATA: at each sample instant, shift the sample into a shadow register, LSB first. After DataBits samples, go to PARITY if Parity != 0, else STOP.
- PARITY: sample and compare against the XOR of the data bits (odd: XOR^sample must be 1; even: 0). Latch the mismatch, then go to STOP.
- STOP: take StopBits samples; each must equal IdleLevel.
  - Any mismatch: pulse `frame_err` for one `ref_clk` cycle, discard the word, leave `valid`, `out` and `parity_err` unchanged, and go to IDLE at that sample.
  - All good: load `out` and `parity_err` from the shadow, set `valid`, and go to IDLE.
- Handshake: `ack` with `valid`=1 clears `valid` and `parity_err` on the same edge. `ack` with `valid`=0 is ignored.
- Simultaneous completion and `ack`: the new word loads, `valid` stays 1, and no overrun is flagged.
- Completion with `valid`=1 and no `ack`: the new word overwrites `out` and `overrun` sets. `overrun` clears only on reset or on an `ack`.
- `reset` takes priority over every other event, including a frame in progress; the partial frame is discarded.

## Timing
- The detection tick is tick 0. Sample j (j=0 is the start bit) falls at tick N/2 + j·N. F = 1 + DataBits + (Parity != 0) + StopBits.
- `valid` rises on the `ref_clk` edge of tick N/2 + (F-1)·N. Example: 8N1 with N=8 gives tick 76.
- `frame_err` fires at the first bad stop sample.
- IDLE is re-entered right after the final stop sample, so a back-to-back start bit is detected on the next tick.
- `ack` to `valid` low takes one `ref_clk` edge.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit is decided by a 2-of-3 majority of the samples at phases N/2-2, N/2-1 and N/2. The decision instant moves to phase N/2, adding one tick to all latencies above. Requires Oversample >= 2.
- Undefined: a single sample at phase N/2-1; no extra registers.

## Test plan
- 8N1, IdleLevel=0, N=8, frame 0xA5 sent LSB first: `out`=0xA5, `valid`=1 at tick 76, `parity_err`=0, no `frame_err`.
- Parity=2 (even), 0x03 sent with parity bit 1: `valid`=1, `parity_err`=1. Resend with parity bit 0: `parity_err`=0.
- 8N2 with the second stop bit at the start level: one-cycle `frame_err` at tick 4+80=84, `valid` stays 0, and the next good frame 0x5A is received correctly.
- Two frames 0x11 then 0x22 with no `ack`: `out`=0x22, `overrun`=1. Then `ack`: `valid`=0, `overrun`=0.
- A 2-tick start glitch: returns to IDLE, `busy` low by tick 5, no outputs change. `reset` asserted mid-DATA: all outputs 0 on the next edge.
- `UART_RX_MAJORITY_EN` defined, single-tick inversion at phase N/2-1 of data bit 3 of 0x00: `out`=0x00, `valid` at tick 77.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line input and held valid/ack word output of the UART receiver
// samp_clk  oversample tick enable, in  serial line, ack  consumer accepts out
// out  received word, valid  unread word held, parity_err  parity of out wrong,
// frame_err  bad stop bit pulse, overrun  sticky overwrite flag, busy  frame in progress
interface uart_rx_param_if #(parameter int DataBits = 8);
  logic samp_clk, in, ack, valid, parity_err, frame_err, overrun, busy;
  logic [DataBits-1:0] out;
  modport master (output samp_clk, in, ack, input out, valid, parity_err, frame_err, overrun, busy);
  modport slave (input samp_clk, in, ack, output out, valid, parity_err, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity, 1/2 stop bits, polarity and held valid/ack output
// ref_clk  system clock, reset  synchronous active-high reset, bus  uart_rx_param_if.slave
// UART_RX_MAJORITY_EN: decide each bit by 2-of-3 majority around the bit centre, one tick later
module uart_rx_param #(
  parameter int Oversample = 3,
  parameter int DataBits = 8,
  parameter int Parity = 0,
  parameter int StopBits = 1,
  parameter logic IdleLevel = 1'b0
) (
  input logic ref_clk,
  input logic reset,
  uart_rx_param_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [Oversample-1:0] phase;
  logic [3:0] cnt;
  logic [DataBits-1:0] sh;
  logic perr, smp, inst, bad, done;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [Oversample-1:0] P0 = Oversample'((1 << (Oversample - 1)) - 2);
  localparam logic [Oversample-1:0] P1 = Oversample'((1 << (Oversample - 1)) - 1);
  localparam logic [Oversample-1:0] PD = Oversample'(1 << (Oversample - 1));
  logic s0, s1;
  always_ff @(posedge ref_clk)
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (bus.samp_clk) begin
      if (phase == P0) s0 <= bus.in;
      if (phase == P1) s1 <= bus.in;
    end
  assign smp = (s0 & s1) | (s0 & bus.in) | (s1 & bus.in);
  assign inst = bus.samp_clk && phase == PD;
`else
  localparam logic [Oversample-1:0] P1 = Oversample'((1 << (Oversample - 1)) - 1);
  assign smp = bus.in;
  assign inst = bus.samp_clk && phase == P1;
`endif
  always_comb begin
    bad = smp != IdleLevel;
    done = inst && state == STOP && !bad && cnt == 4'(StopBits - 1);
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge ref_clk)
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      sh <= '0;
      perr <= 1'b0;
    end else if (bus.samp_clk) begin
      phase <= state == IDLE ? '0 : phase + 1'b1;
      case (state)
        IDLE: if (bus.in != IdleLevel) state <= START;
        START: if (inst) begin
          state <= smp == IdleLevel ? IDLE : DATA;
          cnt <= '0;
          perr <= 1'b0;
        end
        DATA: if (inst) begin
          sh <= {smp, sh[DataBits-1:1]};
          cnt <= cnt == 4'(DataBits - 1) ? 4'd0 : cnt + 1'b1;
          if (cnt == 4'(DataBits - 1)) state <= Parity != 0 ? PARITY : STOP;
        end
        // odd parity wants data^bit == 1, even wants 0; the extra term flips the sense for odd
        PARITY: if (inst) begin
          perr <= ^sh ^ smp ^ (Parity == 1);
          state <= STOP;
        end
        STOP: if (inst) begin
          cnt <= cnt + 1'b1;
          if (bad || done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge ref_clk)
    if (reset) begin
      bus.out <= '0;
      bus.valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.frame_err <= inst && state == STOP && bad;
      if (done) bus.out <= sh;
      bus.valid <= done | (bus.valid & ~bus.ack);
      bus.parity_err <= done ? perr : (bus.valid & bus.ack) ? 1'b0 : bus.parity_err;
      bus.overrun <= (done & bus.valid & ~bus.ack) ? 1'b1 : (bus.valid & bus.ack) ? 1'b0 : bus.overrun;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations (8N1, 8E1, 8N2 idle-high) driven from one line
module tb_uart_rx_param;
  localparam int N = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int DL = 1;
`else
  localparam int DL = 0;
`endif
  typedef struct {
    int sel;
    logic [7:0] d;
    logic pb;
    logic [7:0] xo;
    logic xp;
    int xt;
  } row_t;
  logic clk = 1'b0, rst = 1'b1, samp = 1'b0, line = 1'b0, ack = 1'b0;
  int total = 0, bad = 0, tc = 0;
  logic [2:0] vh [0:255];
  logic [2:0] fh [0:255];
  logic [2:0] bh [0:255];
  logic [7:0] o [0:2];
  logic [2:0] v, pe, fe, ov, bz;
  row_t tbl [0:6];
  always #5 clk = ~clk;
  uart_rx_param_if #(.DataBits(8)) i0 ();
  uart_rx_param_if #(.DataBits(8)) i1 ();
  uart_rx_param_if #(.DataBits(8)) i2 ();
  assign i0.samp_clk = samp;
  assign i0.in = line;
  assign i0.ack = ack;
  assign i1.samp_clk = samp;
  assign i1.in = line;
  assign i1.ack = ack;
  assign i2.samp_clk = samp;
  assign i2.in = ~line;
  assign i2.ack = ack;
  assign o[0] = i0.out;
  assign o[1] = i1.out;
  assign o[2] = i2.out;
  assign v = {i2.valid, i1.valid, i0.valid};
  assign pe = {i2.parity_err, i1.parity_err, i0.parity_err};
  assign fe = {i2.frame_err, i1.frame_err, i0.frame_err};
  assign ov = {i2.overrun, i1.overrun, i0.overrun};
  assign bz = {i2.busy, i1.busy, i0.busy};
  uart_rx_param #(.Oversample(3), .DataBits(8), .Parity(0), .StopBits(1), .IdleLevel(1'b0))
    d0 (.ref_clk(clk), .reset(rst), .bus(i0.slave));
  uart_rx_param #(.Oversample(3), .DataBits(8), .Parity(2), .StopBits(1), .IdleLevel(1'b0))
    d1 (.ref_clk(clk), .reset(rst), .bus(i1.slave));
  uart_rx_param #(.Oversample(3), .DataBits(8), .Parity(0), .StopBits(2), .IdleLevel(1'b1))
    d2 (.ref_clk(clk), .reset(rst), .bus(i2.slave));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one idle clock, then one tick cycle; outputs recorded just after the tick edge
  task automatic do_tick(input logic b);
    @(posedge clk);
    #1 line = b;
    samp = 1'b1;
    @(posedge clk);
    #1 samp = 1'b0;
    if (tc < 256) begin
      vh[tc] = v;
      fh[tc] = fe;
      bh[tc] = bz;
    end
    tc++;
  endtask

  // line-level frame as the receiving DUT sees it; unused high bits sit at idle
  function automatic logic [15:0] mkf(input logic [7:0] d, input logic idle, input int np,
                                      input logic pb, input int ns, input logic [1:0] sb);
    logic [15:0] f;
    f = {16{idle}};
    f[0] = ~idle;
    f[8:1] = d;
    if (np != 0) f[9] = pb;
    for (int i = 0; i < ns; i++) f[9 + np + i] = idle ^ sb[i];
    return f;
  endfunction

  task automatic send(input logic [15:0] fr, input int nt, input logic inv, input int flip);
    tc = 0;
    for (int t = 0; t < nt; t++) do_tick(fr[t / N] ^ inv ^ (t == flip));
  endtask

  function automatic int rise(input int s);
    for (int t = 0; t < tc && t < 256; t++) if (vh[t][s]) return t;
    return -1;
  endfunction

  function automatic int fcount(input int s);
    int c = 0;
    for (int t = 0; t < tc && t < 256; t++) if (fh[t][s]) c++;
    return c;
  endfunction

  initial begin
    logic [7:0] d, mo;
    logic pb, inj, sb, mv, mp, movr;
    int s;
    tbl[0] = '{0, 8'hA5, 1'b0, 8'hA5, 1'b0, 76};
    tbl[1] = '{0, 8'h00, 1'b0, 8'h00, 1'b0, 76};
    tbl[2] = '{0, 8'hFF, 1'b0, 8'hFF, 1'b0, 76};
    tbl[3] = '{1, 8'h03, 1'b1, 8'h03, 1'b1, 84};
    tbl[4] = '{1, 8'h03, 1'b0, 8'h03, 1'b0, 84};
    tbl[5] = '{1, 8'h80, 1'b0, 8'h80, 1'b1, 84};
    tbl[6] = '{1, 8'h80, 1'b1, 8'h80, 1'b0, 84};
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset valid", v, 0);
    chk("reset perr", pe, 0);
    chk("reset ferr", fe, 0);
    chk("reset ovr", ov, 0);
    chk("reset busy", bz, 0);
    chk("reset out", o[0], 0);
    for (int r = 0; r < 7; r++) begin
      do_reset();
      s = tbl[r].sel;
      send(mkf(tbl[r].d, 1'b0, s, tbl[r].pb, 1, 2'b00), (s != 0 ? 88 : 80) + 4, 1'b0, -1);
      chk($sformatf("row%0d out", r), o[s], tbl[r].xo);
      chk($sformatf("row%0d perr", r), pe[s], tbl[r].xp);
      chk($sformatf("row%0d valid tick", r), rise(s), tbl[r].xt + DL);
      chk($sformatf("row%0d ferr", r), fcount(s), 0);
    end
    // 8N2 idle-high: second stop bit wrong, then a clean frame
    do_reset();
    send(mkf(8'hC3, 1'b1, 0, 1'b0, 2, 2'b10), 85 + DL, 1'b1, -1);
    chk("n2 ferr tick", fh[84 + DL][2], 1);
    chk("n2 ferr early", fh[83 + DL][2], 0);
    chk("n2 ferr count", fcount(2), 1);
    chk("n2 valid", v[2], 0);
    @(posedge clk);
    #1 chk("n2 ferr width", fe[2], 0);
    send(mkf(8'h5A, 1'b1, 0, 1'b0, 2, 2'b00), 92, 1'b1, -1);
    chk("n2 out", o[2], 8'h5A);
    chk("n2 valid tick", rise(2), 84 + DL);
    chk("n2 no ferr", fcount(2), 0);
    // back-to-back frames without ack, then ack
    do_reset();
    send(mkf(8'h11, 1'b0, 0, 1'b0, 1, 2'b00), 80, 1'b0, -1);
    chk("ovr first out", o[0], 8'h11);
    chk("ovr first flag", ov[0], 0);
    send(mkf(8'h22, 1'b0, 0, 1'b0, 1, 2'b00), 80, 1'b0, -1);
    chk("ovr out", o[0], 8'h22);
    chk("ovr flag", ov[0], 1);
    chk("ovr valid", v[0], 1);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("ack valid", v[0], 0);
    chk("ack ovr", ov[0], 0);
    chk("ack out kept", o[0], 8'h22);
    // reset in the middle of a data bit
    send(mkf(8'h33, 1'b0, 0, 1'b0, 1, 2'b00), 80, 1'b0, -1);
    send(mkf(8'h44, 1'b0, 0, 1'b0, 1, 2'b00), 80, 1'b0, -1);
    send(mkf(8'h55, 1'b0, 0, 1'b0, 1, 2'b00), 30, 1'b0, -1);
    chk("mid busy", bh[29][0], 1);
    chk("mid ovr", ov[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid rst out", o[0], 0);
    chk("mid rst valid", v[0], 0);
    chk("mid rst ovr", ov[0], 0);
    chk("mid rst busy", bz[0], 0);
    chk("mid rst perr", pe[0], 0);
    // two-tick start glitch
    tc = 0;
    do_tick(1'b1);
    do_tick(1'b1);
    repeat (6) do_tick(1'b0);
    chk("glitch busy0", bh[0][0], 1);
    chk("glitch busy5", bh[5][0], 0);
    chk("glitch valid", rise(0), -1);
    chk("glitch ferr", fcount(0), 0);
    chk("glitch out", o[0], 0);
    // single-tick inversion at the centre sample of data bit 3
    do_reset();
    send(mkf(8'h00, 1'b0, 0, 1'b0, 1, 2'b00), 84, 1'b0, 36);
    chk("flip out", o[0], DL != 0 ? 8'h00 : 8'h08);
    chk("flip valid tick", rise(0), 76 + DL);
    // random frames on 8E1 against a word-level model
    do_reset();
    mv = 1'b0;
    mp = 1'b0;
    movr = 1'b0;
    mo = 8'h00;
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      inj = ($urandom % 4) == 0;
      sb = ($urandom % 6) == 0;
      pb = (^d) ^ inj;
      if ($urandom % 2 != 0) begin
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        if (mv) begin
          mv = 1'b0;
          mp = 1'b0;
          movr = 1'b0;
        end
      end
      send(mkf(d, 1'b0, 1, pb, 1, {1'b0, sb}), sb ? 85 + DL : 88, 1'b0, -1);
      if (!sb) begin
        if (mv) movr = 1'b1;
        mo = d;
        mp = ^{d, pb};
        mv = 1'b1;
      end
      chk($sformatf("rnd%0d ferr", k), fcount(1), int'(sb));
      chk($sformatf("rnd%0d out", k), o[1], mo);
      chk($sformatf("rnd%0d valid", k), v[1], mv);
      chk($sformatf("rnd%0d perr", k), pe[1], mp);
      chk($sformatf("rnd%0d ovr", k), ov[1], movr);
      repeat ($urandom_range(3, 0)) do_tick(1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
